// File: rtl/siphash_pkg.sv
// -----------------------------------------------------------------------------
// siphash_pkg
// Shared definitions for the parametrised SipHash core:
//   - initialisation vectors XORed into the key at init
//   - padding bytes used by finalization (ff / ee / dd) and the 128-bit v1 tweak
//   - FSM state encoding
//   - ROUNDS_PER_CYCLE legality check and a 64-bit rotate helper
// -----------------------------------------------------------------------------
package siphash_pkg;

  localparam logic [63:0] IV0 = 64'h736f6d6570736575;
  localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2 = 64'h6c7967656e657261;
  localparam logic [63:0] IV3 = 64'h7465646279746573;

  // XORed into v1 at init when 128-bit output is selected
  localparam logic [63:0] LONG_V1_TWEAK = 64'h00000000000000ee;

  localparam logic [7:0] PAD_FIN64  = 8'hff;
  localparam logic [7:0] PAD_FIN128 = 8'hee;
  localparam logic [7:0] PAD_OUT1   = 8'hdd;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMP_RND = 3'd1,
    ST_COMP_END = 3'd2,
    ST_FIN_RND0 = 3'd3,
    ST_OUT0     = 3'd4,
    ST_FIN_RND1 = 3'd5,
    ST_OUT1     = 3'd6
  } state_e;

  // Only one or two chained SipRounds per clock are supported
  function automatic bit rpc_legal(input int unsigned rpc);
    return (rpc == 32'd1) || (rpc == 32'd2);
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (32'd64 - n));
  endfunction

endpackage

// File: rtl/siphash_core_param_if.sv
// -----------------------------------------------------------------------------
// siphash_core_param_if
// Command/result bundle of the SipHash core.
//   master: drives init/compress/finalize pulses, long_mode, c, d, k, mi
//   slave : the core; drives ready, siphash_word (128b), siphash_word_valid
// -----------------------------------------------------------------------------
interface siphash_core_param_if;
  import siphash_pkg::*;

  logic         init;
  logic         compress;
  logic         finalize;
  logic         long_mode;
  logic [3:0]   c;
  logic [3:0]   d;
  logic [127:0] k;
  logic [63:0]  mi;
  logic         ready;
  logic [127:0] siphash_word;
  logic         siphash_word_valid;

  modport master (
    output init, compress, finalize, long_mode, c, d, k, mi,
    input  ready, siphash_word, siphash_word_valid
  );

  modport slave (
    input  init, compress, finalize, long_mode, c, d, k, mi,
    output ready, siphash_word, siphash_word_valid
  );

endinterface

// File: rtl/siphash_round.sv
// -----------------------------------------------------------------------------
// siphash_round
// One combinational SipRound.
//   v0_i..v3_i : state in
//   v0_o..v3_o : state after one round (adds mod 2^64)
// -----------------------------------------------------------------------------
module siphash_round
  import siphash_pkg::*;
(
  input  logic [63:0] v0_i,
  input  logic [63:0] v1_i,
  input  logic [63:0] v2_i,
  input  logic [63:0] v3_i,
  output logic [63:0] v0_o,
  output logic [63:0] v1_o,
  output logic [63:0] v2_o,
  output logic [63:0] v3_o
);

  logic [63:0] a0_s, a1_s, a2_s, a3_s;
  logic [63:0] b0_s, b1_s, b2_s, b3_s;

  // first half: two independent ARX lanes (v0/v1 and v2/v3)
  assign a0_s = v0_i + v1_i;
  assign a1_s = rotl64(v1_i, 32'd13) ^ a0_s;
  assign a2_s = v2_i + v3_i;
  assign a3_s = rotl64(v3_i, 32'd16) ^ a2_s;

  // second half: lanes cross (v0 with v3, v2 with v1); v0 is rotated by 32 first
  assign b0_s = rotl64(a0_s, 32'd32) + a3_s;
  assign b3_s = rotl64(a3_s, 32'd21) ^ b0_s;
  assign b2_s = a2_s + a1_s;
  assign b1_s = rotl64(a1_s, 32'd17) ^ b2_s;

  assign v0_o = b0_s;
  assign v1_o = b1_s;
  assign v2_o = rotl64(b2_s, 32'd32);
  assign v3_o = b3_s;

endmodule

// File: rtl/siphash_core_param.sv
// -----------------------------------------------------------------------------
// siphash_core_param
// SipHash-c-d core with 64- or 128-bit output and 1 or 2 SipRounds per clock.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : init/compress/finalize command pulses (accepted only when
//                  ready, priority init > compress > finalize), long_mode
//                  (sampled on init), c (on compress), d (on finalize),
//                  k = {k1,k0}, mi; registered ready, siphash_word
//                  ({second,first}) and siphash_word_valid
// -----------------------------------------------------------------------------
module siphash_core_param #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  siphash_core_param_if.slave  bus
);
  import siphash_pkg::*;

  generate
    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
      $error("siphash_core_param: ROUNDS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [63:0]   v0_q, v1_q, v2_q, v3_q;
  logic [63:0]   v0_d, v1_d, v2_d, v3_d;
  logic [63:0]   mi_q, mi_d;
  logic          mode_q, mode_d;
  logic [3:0]    target_q, target_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [127:0]  word_q, word_d;
  logic          valid_q, valid_d;

  logic [63:0]   r1_v0_s, r1_v1_s, r1_v2_s, r1_v3_s;
  logic [63:0]   rn_v0_s, rn_v1_s, rn_v2_s, rn_v3_s;
  logic [4:0]    cnt_step_s;
  logic          rounds_done_s;
  logic [63:0]   xor_s;
  logic [63:0]   k0_s, k1_s;

  assign k0_s  = bus.k[63:0];
  assign k1_s  = bus.k[127:64];
  assign xor_s = v0_q ^ v1_q ^ v2_q ^ v3_q;

  siphash_round u_round0 (
    .v0_i (v0_q),    .v1_i (v1_q),    .v2_i (v2_q),    .v3_i (v3_q),
    .v0_o (r1_v0_s), .v1_o (r1_v1_s), .v2_o (r1_v2_s), .v3_o (r1_v3_s)
  );

  generate
    if (ROUNDS_PER_CYCLE == 32'd2) begin : g_unroll2
      logic [63:0] r2_v0_s, r2_v1_s, r2_v2_s, r2_v3_s;
      logic [4:0]  rem_s;
      logic        take_two_s;

      siphash_round u_round1 (
        .v0_i (r1_v0_s), .v1_i (r1_v1_s), .v2_i (r1_v2_s), .v3_i (r1_v3_s),
        .v0_o (r2_v0_s), .v1_o (r2_v1_s), .v2_o (r2_v2_s), .v3_o (r2_v3_s)
      );

      // with an odd round count the final cycle bypasses the second round
      assign rem_s      = {1'b0, target_q} - cnt_q;
      assign take_two_s = (rem_s >= 5'd2);
      assign rn_v0_s    = take_two_s ? r2_v0_s : r1_v0_s;
      assign rn_v1_s    = take_two_s ? r2_v1_s : r1_v1_s;
      assign rn_v2_s    = take_two_s ? r2_v2_s : r1_v2_s;
      assign rn_v3_s    = take_two_s ? r2_v3_s : r1_v3_s;
      assign cnt_step_s = cnt_q + (take_two_s ? 5'd2 : 5'd1);
    end else begin : g_unroll1
      assign rn_v0_s    = r1_v0_s;
      assign rn_v1_s    = r1_v1_s;
      assign rn_v2_s    = r1_v2_s;
      assign rn_v3_s    = r1_v3_s;
      assign cnt_step_s = cnt_q + 5'd1;
    end
  endgenerate

  assign rounds_done_s = (cnt_step_s >= {1'b0, target_q});

  // next-state, datapath update and registered-output logic of the command FSM
  always_comb begin
    state_d  = state_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    mi_d     = mi_q;
    mode_d   = mode_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    word_d   = word_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.init) begin
          v0_d    = k0_s ^ IV0;
          v1_d    = k1_s ^ IV1 ^ (bus.long_mode ? LONG_V1_TWEAK : 64'd0);
          v2_d    = k0_s ^ IV2;
          v3_d    = k1_s ^ IV3;
          mode_d  = bus.long_mode;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end else if (bus.compress) begin
          mi_d     = bus.mi;
          v3_d     = v3_q ^ bus.mi;
          target_d = bus.c;
          cnt_d    = 5'd0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
          state_d  = (bus.c == 4'd0) ? ST_COMP_END : ST_COMP_RND;
        end else if (bus.finalize) begin
          v2_d     = v2_q ^ {56'd0, (mode_q ? PAD_FIN128 : PAD_FIN64)};
          target_d = bus.d;
          cnt_d    = 5'd0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
          state_d  = (bus.d == 4'd0) ? ST_OUT0 : ST_FIN_RND0;
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_COMP_RND, ST_FIN_RND0, ST_FIN_RND1: begin
        v0_d  = rn_v0_s;
        v1_d  = rn_v1_s;
        v2_d  = rn_v2_s;
        v3_d  = rn_v3_s;
        cnt_d = cnt_step_s;
        if (rounds_done_s) begin
          case (state_q)
            ST_COMP_RND: state_d = ST_COMP_END;
            ST_FIN_RND0: state_d = ST_OUT0;
            ST_FIN_RND1: state_d = ST_OUT1;
            default:     state_d = ST_IDLE;
          endcase
        end else begin
          state_d = state_q;
        end
      end

      ST_COMP_END: begin
        v0_d    = v0_q ^ mi_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      ST_OUT0: begin
        word_d[63:0] = xor_s;
        if (mode_q) begin
          // second output word: tweak v1 and rerun d rounds
          v1_d    = v1_q ^ {56'd0, PAD_OUT1};
          cnt_d   = 5'd0;
          state_d = (target_q == 4'd0) ? ST_OUT1 : ST_FIN_RND1;
        end else begin
          word_d[127:64] = 64'd0;
          ready_d        = 1'b1;
          valid_d        = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      ST_OUT1: begin
        word_d[127:64] = xor_s;
        ready_d        = 1'b1;
        valid_d        = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      v0_q     <= 64'd0;
      v1_q     <= 64'd0;
      v2_q     <= 64'd0;
      v3_q     <= 64'd0;
      mi_q     <= 64'd0;
      mode_q   <= 1'b0;
      target_q <= 4'd0;
      cnt_q    <= 5'd0;
      ready_q  <= 1'b1;
      word_q   <= 128'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      mi_q     <= mi_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready              = ready_q;
  assign bus.siphash_word       = word_q;
  assign bus.siphash_word_valid = valid_q;

endmodule

// File: tb/tb_siphash_core_param.sv
// -----------------------------------------------------------------------------
// tb_siphash_core_param
// Drives one R=1 and one R=2 core with the same command stream and compares
// results and latencies against a straightforward SipHash model.
// -----------------------------------------------------------------------------
module tb_siphash_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         init_s, compress_s, finalize_s, long_mode_s;
  logic [3:0]   c_s, d_s;
  logic [127:0] k_s;
  logic [63:0]  mi_s;

  siphash_core_param_if bus1();
  siphash_core_param_if bus2();

  assign bus1.init = init_s;          assign bus2.init = init_s;
  assign bus1.compress = compress_s;  assign bus2.compress = compress_s;
  assign bus1.finalize = finalize_s;  assign bus2.finalize = finalize_s;
  assign bus1.long_mode = long_mode_s; assign bus2.long_mode = long_mode_s;
  assign bus1.c = c_s;                assign bus2.c = c_s;
  assign bus1.d = d_s;                assign bus2.d = d_s;
  assign bus1.k = k_s;                assign bus2.k = k_s;
  assign bus1.mi = mi_s;              assign bus2.mi = mi_s;

  siphash_core_param #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  siphash_core_param #(.ROUNDS_PER_CYCLE(2)) u_dut_r2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0]  mv [4];
  logic         m_long;
  logic [127:0] m_word;

  function automatic logic [63:0] rol(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  task automatic m_rounds(input int n);
    for (int i = 0; i < n; i++) begin
      mv[0] = mv[0] + mv[1]; mv[1] = rol(mv[1], 13) ^ mv[0]; mv[0] = rol(mv[0], 32);
      mv[2] = mv[2] + mv[3]; mv[3] = rol(mv[3], 16) ^ mv[2];
      mv[0] = mv[0] + mv[3]; mv[3] = rol(mv[3], 21) ^ mv[0];
      mv[2] = mv[2] + mv[1]; mv[1] = rol(mv[1], 17) ^ mv[2]; mv[2] = rol(mv[2], 32);
    end
  endtask

  task automatic m_init(input logic [127:0] key, input logic lm);
    mv[0] = key[63:0]   ^ 64'h736f6d6570736575;
    mv[1] = key[127:64] ^ 64'h646f72616e646f6d ^ (lm ? 64'hee : 64'h0);
    mv[2] = key[63:0]   ^ 64'h6c7967656e657261;
    mv[3] = key[127:64] ^ 64'h7465646279746573;
    m_long = lm;
  endtask

  task automatic m_compress(input logic [63:0] m, input int cr);
    mv[3] = mv[3] ^ m;
    m_rounds(cr);
    mv[0] = mv[0] ^ m;
  endtask

  task automatic m_finalize(input int dr);
    logic [63:0] lo, hi;
    mv[2] = mv[2] ^ (m_long ? 64'hee : 64'hff);
    m_rounds(dr);
    lo = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    hi = 64'h0;
    if (m_long) begin
      mv[1] = mv[1] ^ 64'hdd;
      m_rounds(dr);
      hi = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    end
    m_word = {hi, lo};
  endtask

  function automatic int ncyc(input int r, input int rpc);
    return (r + rpc - 1) / rpc;
  endfunction

  // ---------------- stimulus helpers ----------------
  // mask: [0] init, [1] compress, [2] finalize; returns at the negedge after the accept edge
  task automatic pulse(input logic [2:0] mask);
    @(negedge clk);
    init_s = mask[0]; compress_s = mask[1]; finalize_s = mask[2];
    @(negedge clk);
    init_s = 1'b0; compress_s = 1'b0; finalize_s = 1'b0;
  endtask

  // edges (counting the accept edge) until each core shows ready again
  task automatic wait_idle(output int lat1, output int lat2);
    lat1 = -1; lat2 = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (lat1 < 0 && bus1.ready) lat1 = cyc;
      if (lat2 < 0 && bus2.ready) lat2 = cyc;
      if (lat1 >= 0 && lat2 >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic do_init(input logic [127:0] key, input logic lm);
    int l1, l2;
    k_s = key; long_mode_s = lm;
    pulse(3'b001);
    m_init(key, lm);
    wait_idle(l1, l2);
    check_eq("init_ready_r1", l1, 1);
    check_eq("init_ready_r2", l2, 1);
    check_eq("init_valid_r1", bus1.siphash_word_valid, 1'b0);
    check_eq("init_valid_r2", bus2.siphash_word_valid, 1'b0);
  endtask

  task automatic do_compress(input logic [63:0] m, input logic [3:0] cr);
    int l1, l2;
    mi_s = m; c_s = cr;
    pulse(3'b010);
    m_compress(m, cr);
    wait_idle(l1, l2);
    check_eq("comp_lat_r1", l1, ncyc(cr, 1) + 2);
    check_eq("comp_lat_r2", l2, ncyc(cr, 2) + 2);
  endtask

  task automatic do_finalize(input logic [3:0] dr);
    int l1, l2;
    d_s = dr;
    pulse(3'b100);
    m_finalize(dr);
    wait_idle(l1, l2);
    check_eq("fin_lat_r1", l1, m_long ? 2 * ncyc(dr, 1) + 3 : ncyc(dr, 1) + 2);
    check_eq("fin_lat_r2", l2, m_long ? 2 * ncyc(dr, 2) + 3 : ncyc(dr, 2) + 2);
    check_eq("fin_word_r1", bus1.siphash_word, m_word);
    check_eq("fin_word_r2", bus2.siphash_word, m_word);
    check_eq("fin_valid_r1", bus1.siphash_word_valid, 1'b1);
    check_eq("fin_valid_r2", bus2.siphash_word_valid, 1'b1);
  endtask

  task automatic run_kat64;
    do_init(STD_KEY, 1'b0);
    do_compress(64'h0, 4'd2);
    do_finalize(4'd4);
    check_eq("kat64_r1", bus1.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
    check_eq("kat64_r2", bus2.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int l1, l2;
    logic [127:0] key;
    reset_n = 1'b0;
    init_s = 1'b0; compress_s = 1'b0; finalize_s = 1'b0; long_mode_s = 1'b0;
    c_s = 4'd0; d_s = 4'd0; k_s = 128'd0; mi_s = 64'd0;
    m_word = 128'd0; m_long = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready_r1", bus1.ready, 1'b1);
    check_eq("rst_ready_r2", bus2.ready, 1'b1);
    check_eq("rst_valid_r1", bus1.siphash_word_valid, 1'b0);
    check_eq("rst_valid_r2", bus2.siphash_word_valid, 1'b0);
    check_eq("rst_word_r1", bus1.siphash_word, 128'd0);
    check_eq("rst_word_r2", bus2.siphash_word, 128'd0);
    reset_n = 1'b1;

    // SipHash-2-4 known answers, 64- and 128-bit output
    run_kat64();
    do_init(STD_KEY, 1'b1);
    check_eq("hold_after_init_r1", bus1.siphash_word, m_word);
    do_compress(64'h0, 4'd2);
    do_finalize(4'd4);
    check_eq("kat128_r1", bus1.siphash_word, {64'h930255c71472f66d, 64'he6a825ba047f81a3});
    check_eq("kat128_r2", bus2.siphash_word, {64'h930255c71472f66d, 64'he6a825ba047f81a3});

    // odd round counts c=3, d=5, both modes
    for (int lm = 0; lm < 2; lm++) begin
      do_init(STD_KEY, lm[0]);
      do_compress({$urandom, $urandom}, 4'd3);
      do_finalize(4'd5);
    end

    // zero round counts
    for (int lm = 0; lm < 2; lm++) begin
      do_init({$urandom, $urandom, $urandom, $urandom}, lm[0]);
      do_compress({$urandom, $urandom}, 4'd0);
      do_finalize(4'd0);
    end

    // commands and input changes while busy are ignored
    key = {$urandom, $urandom, $urandom, $urandom};
    do_init(key, 1'b0);
    do_compress({$urandom, $urandom}, 4'd2);
    d_s = 4'd15;
    pulse(3'b100);
    m_finalize(15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      init_s = 1'b1; compress_s = 1'b1; finalize_s = 1'b1;
      k_s = ~k_s; c_s = 4'd7; d_s = 4'd1; long_mode_s = 1'b1; mi_s = {$urandom, $urandom};
    end
    @(negedge clk);
    init_s = 1'b0; compress_s = 1'b0; finalize_s = 1'b0;
    wait_idle(l1, l2);
    check_eq("busy_lat_r1", l1, 17 - 4);
    check_eq("busy_lat_r2", l2, 10 - 4);
    check_eq("busy_word_r1", bus1.siphash_word, m_word);
    check_eq("busy_word_r2", bus2.siphash_word, m_word);

    // all three commands together in IDLE: only init takes effect
    key = {$urandom, $urandom, $urandom, $urandom};
    k_s = key; long_mode_s = 1'b1;
    pulse(3'b111);
    m_init(key, 1'b1);
    check_eq("all3_ready_r1", bus1.ready, 1'b1);
    check_eq("all3_ready_r2", bus2.ready, 1'b1);
    check_eq("all3_valid_r1", bus1.siphash_word_valid, 1'b0);
    check_eq("all3_valid_r2", bus2.siphash_word_valid, 1'b0);
    do_compress({$urandom, $urandom}, 4'd2);
    do_finalize(4'd4);

    // randomized messages, modes and round counts
    for (int t = 0; t < 8; t++) begin
      int nm;
      do_init({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      nm = $urandom_range(1, 3);
      for (int j = 0; j < nm; j++) do_compress({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      do_finalize(4'($urandom_range(0, 15)));
    end

    // asynchronous reset during the finalize round phase
    do_init(STD_KEY, 1'b0);
    do_compress(64'h0, 4'd2);
    d_s = 4'd4;
    pulse(3'b100);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_ready_r1", bus1.ready, 1'b1);
    check_eq("midrst_ready_r2", bus2.ready, 1'b1);
    check_eq("midrst_valid_r1", bus1.siphash_word_valid, 1'b0);
    check_eq("midrst_word_r1", bus1.siphash_word, 128'd0);
    check_eq("midrst_word_r2", bus2.siphash_word, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_kat64();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
